// File: rtl/matrix_reg_readout_pkg.sv
// Shared types and constants for the matrix register readout block.
// State encoding, byte width and byte-count helper.
package matrix_reg_readout_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  function automatic int bytes_per_reg(input int width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/matrix_shift_out.sv
// Snapshot register that presents its top byte and shifts left one byte per step.
// Load wins over shift; both resets clear the register, so an emptied register reads as zero.
module matrix_shift_out
  import matrix_reg_readout_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sync_rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WIDTH-1:0]  i_load_dat,
  output logic [BYTE_W-1:0] o_byte
);

  logic [WIDTH-1:0] r_sreg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sreg <= '0;
    end else if (i_sync_rst) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= i_load_dat;
    end else if (i_shift) begin
      r_sreg <= r_sreg << BYTE_W;
    end
  end

  assign o_byte = r_sreg[WIDTH-1 -: BYTE_W];

endmodule

// File: rtl/matrix_reg_readout.sv
// Host read port for the ID-filter register bank: snapshot one register, stream it MSB byte first.
// First byte valid one cycle after the accepted request; stalls hold the byte while ready is low.
module matrix_reg_readout
  import matrix_reg_readout_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_sync_rst,
  input  logic [WIDTH*DEPTH-1:0] i_reg_bank,
  input  logic                   i_read_req,
  input  logic [ADDR_W-1:0]      i_read_addr,
  output logic                   o_busy,
  output logic                   o_addr_err,
  output logic                   o_rd_valid,
  input  logic                   i_rd_ready,
  output logic [BYTE_W-1:0]      o_rd_data,
  output logic                   o_rd_last
);

  localparam int NBYTES = bytes_per_reg(WIDTH);
  localparam int CNT_W  = $clog2(NBYTES) + 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_addr_err;
  logic             w_addr_err_nxt;
  logic             r_rd_valid;
  logic             w_rd_valid_nxt;
  logic             r_rd_last;
  logic             w_rd_last_nxt;

  logic             w_load;
  logic             w_shift;
  logic             w_addr_ok;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_reg;
  logic [ADDR_W:0]  w_addr_ext;

  assign w_addr_ext = {1'b0, i_read_addr};
  assign w_addr_ok  = (w_addr_ext < (ADDR_W+1)'(DEPTH));
  assign w_xfer     = r_rd_valid & i_rd_ready;

  always_comb begin
    w_sel_reg = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_read_addr == ADDR_W'(k)) begin
        w_sel_reg = i_reg_bank[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_addr_err <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else if (i_sync_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_addr_err <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_addr_err <= w_addr_err_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_last  <= w_rd_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_read_req && w_addr_ok) w_state_nxt = ST_SEND;
      ST_SEND: if (w_xfer && r_rd_last)     w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Requests seen outside IDLE fall through untouched: they are dropped, not queued.
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_busy_nxt     = r_busy;
    w_addr_err_nxt = 1'b0;
    w_rd_valid_nxt = r_rd_valid;
    w_rd_last_nxt  = r_rd_last;
    w_load         = 1'b0;
    w_shift        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_read_req) begin
          if (w_addr_ok) begin
            w_load         = 1'b1;
            w_cnt_nxt      = CNT_W'(NBYTES);
            w_busy_nxt     = 1'b1;
            w_rd_valid_nxt = 1'b1;
            w_rd_last_nxt  = (NBYTES == 1);
          end else begin
            w_addr_err_nxt = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (w_xfer) begin
          // The final shift empties the snapshot, which drives the data output back to zero.
          w_shift = 1'b1;
          if (r_rd_last) begin
            w_cnt_nxt      = '0;
            w_busy_nxt     = 1'b0;
            w_rd_valid_nxt = 1'b0;
            w_rd_last_nxt  = 1'b0;
          end else begin
            w_cnt_nxt     = r_cnt - CNT_W'(1);
            w_rd_last_nxt = (r_cnt == CNT_W'(2));
          end
        end
      end
      default: begin
        w_busy_nxt     = 1'b0;
        w_rd_valid_nxt = 1'b0;
        w_rd_last_nxt  = 1'b0;
      end
    endcase
  end

  matrix_shift_out #(
    .WIDTH (WIDTH)
  ) u_shift_out (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sync_rst (i_sync_rst),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_load_dat (w_sel_reg),
    .o_byte     (o_rd_data)
  );

  assign o_busy     = r_busy;
  assign o_addr_err = r_addr_err;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_last  = r_rd_last;

endmodule

// File: tb/tb_matrix_reg_readout.sv
// Scoreboard bench: requests push the expected byte stream, a negedge monitor pops on each transfer.
module tb_matrix_reg_readout;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 6;
  localparam int ADDR_W = 3;
  localparam int NB     = WIDTH / 8;

  logic                   i_clk = 1'b0;
  logic                   i_rst;
  logic                   i_sync_rst;
  logic [WIDTH*DEPTH-1:0] i_reg_bank;
  logic                   i_read_req;
  logic [ADDR_W-1:0]      i_read_addr;
  logic                   i_rd_ready;
  logic                   o_busy;
  logic                   o_addr_err;
  logic                   o_rd_valid;
  logic [7:0]             o_rd_data;
  logic                   o_rd_last;

  logic [WIDTH-1:0] m_bank [DEPTH];
  logic [8:0]       sb [$];
  int               n_vec = 0;
  int               n_err = 0;
  bit               hold_chk = 1'b0;
  bit               idle_chk = 1'b0;
  logic [8:0]       held;
  bit               pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  matrix_reg_readout #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sync_rst  (i_sync_rst),
    .i_reg_bank  (i_reg_bank),
    .i_read_req  (i_read_req),
    .i_read_addr (i_read_addr),
    .o_busy      (o_busy),
    .o_addr_err  (o_addr_err),
    .o_rd_valid  (o_rd_valid),
    .i_rd_ready  (i_rd_ready),
    .o_rd_data   (o_rd_data),
    .o_rd_last   (o_rd_last)
  );

  always #5 i_clk = ~i_clk;

  always_comb begin
    i_reg_bank = '0;
    for (int k = 0; k < DEPTH; k++) i_reg_bank[k*WIDTH +: WIDTH] = m_bank[k];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream from the reference: bytes of the snapshot, MSB first, last flag on the final one.
  task automatic push_stream(input logic [WIDTH-1:0] val);
    for (int b = NB - 1; b >= 0; b--) sb.push_back({(b == 0), val[b*8 +: 8]});
  endtask

  always @(negedge i_clk) begin
    if (hold_chk) begin
      if (o_rd_valid) begin
        chk("stall_hold_data", 32'(o_rd_data), 32'(held[7:0]));
        chk("stall_hold_last", 32'(o_rd_last), 32'(held[8]));
      end
      hold_chk = 1'b0;
    end
    if (idle_chk) begin
      chk("idle_busy", 32'(o_busy), 32'd0);
      chk("idle_valid", 32'(o_rd_valid), 32'd0);
      chk("idle_data", 32'(o_rd_data), 32'd0);
      idle_chk = 1'b0;
    end
    if (o_rd_valid) begin
      if (i_rd_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got %0h with nothing expected at %0t", o_rd_data, $time);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("rd_data", 32'(o_rd_data), 32'(e[7:0]));
          chk("rd_last", 32'(o_rd_last), 32'(e[8]));
          if (e[8]) idle_chk = 1'b1;
        end
      end else begin
        hold_chk = 1'b1;
        held     = {o_rd_last, o_rd_data};
      end
    end
  end

  task automatic do_read(input int addr, input int rmode, input bit snap, input bit req_during);
    logic [WIDTH-1:0] val;
    bit               ok;
    int               c;
    ok = (addr < DEPTH);
    @(posedge i_clk); #1;
    i_read_req  = 1'b1;
    i_read_addr = ADDR_W'(addr);
    i_rd_ready  = 1'b1;
    if (ok) begin
      val = m_bank[addr];
      push_stream(val);
    end
    @(posedge i_clk); #1;
    i_read_req = 1'b0;
    chk("addr_err_on_req", 32'(o_addr_err), 32'(!ok));
    chk("busy_on_req", 32'(o_busy), 32'(ok));
    chk("valid_on_req", 32'(o_rd_valid), 32'(ok));
    if (!ok) begin
      @(posedge i_clk); #1;
      chk("addr_err_pulse", 32'(o_addr_err), 32'd0);
      chk("valid_after_bad", 32'(o_rd_valid), 32'd0);
      chk("busy_after_bad", 32'(o_busy), 32'd0);
    end else begin
      chk("first_byte", 32'(o_rd_data), 32'(val[WIDTH-1 -: 8]));
      if (snap) m_bank[addr] = $urandom;
      if (req_during) begin
        i_read_req  = 1'b1;
        i_read_addr = '0;
      end
      c = 0;
      while (o_busy && c < 200) begin
        case (rmode)
          0:       i_rd_ready = 1'b1;
          1:       i_rd_ready = (c < 7) ? pat[c] : 1'b1;
          default: i_rd_ready = 1'($urandom_range(0, 1));
        endcase
        @(posedge i_clk); #1;
        c++;
      end
      i_read_req = 1'b0;
      chk("stream_done_in_time", 32'(c < 200), 32'd1);
      chk("bytes_left", 32'(sb.size()), 32'd0);
      if (req_during) begin
        repeat (3) @(posedge i_clk);
        #1;
        chk("ignored_req_valid", 32'(o_rd_valid), 32'd0);
        chk("ignored_req_busy", 32'(o_busy), 32'd0);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) m_bank[k] = '0;
    i_rst       = 1'b1;
    i_sync_rst  = 1'b0;
    i_read_req  = 1'b1;
    i_read_addr = 3'd2;
    i_rd_ready  = 1'b1;
    m_bank[2]   = 32'hA1B2C3D4;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_data", 32'(o_rd_data), 32'd0);
    chk("rst_last", 32'(o_rd_last), 32'd0);
    chk("rst_addr_err", 32'(o_addr_err), 32'd0);
    @(posedge i_clk); #1;
    i_rst      = 1'b0;
    i_read_req = 1'b0;
    @(posedge i_clk); #1;
    chk("post_rst_valid", 32'(o_rd_valid), 32'd0);
    chk("post_rst_busy", 32'(o_busy), 32'd0);

    do_read(2, 0, 1'b0, 1'b0);

    m_bank[5] = 32'h01020304;
    do_read(5, 1, 1'b0, 1'b0);

    m_bank[0] = 32'h11223344;
    @(posedge i_clk); #1;
    i_read_req  = 1'b1;
    i_read_addr = 3'd0;
    i_rd_ready  = 1'b1;
    push_stream(32'h11223344);
    @(posedge i_clk); #1;
    i_read_req = 1'b0;
    m_bank[0]  = 32'hFFFFFFFF;
    repeat (6) @(posedge i_clk);
    #1;
    chk("snapshot_bytes_left", 32'(sb.size()), 32'd0);

    do_read(7, 0, 1'b0, 1'b0);
    do_read(6, 0, 1'b0, 1'b0);
    m_bank[4] = 32'hCAFEF00D;
    do_read(4, 2, 1'b0, 1'b1);

    m_bank[3] = 32'hDEADBEEF;
    m_bank[1] = 32'h5A6B7C8D;
    @(posedge i_clk); #1;
    i_read_req  = 1'b1;
    i_read_addr = 3'd3;
    i_rd_ready  = 1'b1;
    push_stream(32'hDEADBEEF);
    @(posedge i_clk); #1;
    i_read_req = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("abort_bytes_left", 32'(sb.size()), 32'd2);
    i_sync_rst = 1'b1;
    i_rd_ready = 1'b0;
    sb.delete();
    @(posedge i_clk); #1;
    i_sync_rst = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_valid", 32'(o_rd_valid), 32'd0);
    chk("abort_data", 32'(o_rd_data), 32'd0);
    chk("abort_last", 32'(o_rd_last), 32'd0);
    do_read(1, 0, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      int a;
      a = int'($urandom_range(0, 7));
      if (a < DEPTH) m_bank[a] = $urandom;
      do_read(a, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge i_clk);
    #1;
    chk("final_bytes_left", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
